stream_drr_scheduler: RTL

STREAM_DRR_SCHEDULER -- requirements
Module: stream_drr_scheduler

---
 rtl/stream_drr_scheduler.sv | 130 +++++++++++++
 1 files changed

// File: rtl/stream_drr_scheduler.sv
// Deficit-round-robin packet scheduler: merges STREAM_COUNT ready/valid input
// streams onto one output, never splitting a packet, weighting streams by quantum.
module stream_drr_scheduler #(
  parameter int unsigned T_DATA_WIDTH  = 8,
  parameter int unsigned STREAM_COUNT  = 4,
  parameter int unsigned T_ID_WIDTH    = $clog2(STREAM_COUNT),
  parameter int unsigned WEIGHT_WIDTH  = 4,
  parameter int unsigned DEFICIT_WIDTH = 8
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0]   s_data_in,
  input  logic [STREAM_COUNT-1:0]                     s_last_in,
  input  logic [STREAM_COUNT-1:0]                     s_valid_in,
  output logic [STREAM_COUNT-1:0]                     s_ready_out,
  input  logic [STREAM_COUNT-1:0][WEIGHT_WIDTH-1:0]   s_weight_in,
  output logic [T_DATA_WIDTH-1:0]                     m_data_out,
  output logic [T_ID_WIDTH-1:0]                       m_id_out,
  output logic                                        m_last_out,
  output logic                                        m_valid_out,
  input  logic                                        m_ready_in
);

  localparam int unsigned SUM_WIDTH =
    ((DEFICIT_WIDTH > WEIGHT_WIDTH) ? DEFICIT_WIDTH : WEIGHT_WIDTH) + 1;
  localparam logic [SUM_WIDTH-1:0] D_MAX = SUM_WIDTH'({DEFICIT_WIDTH{1'b1}});

  typedef enum logic [1:0] {IDLE, REFILL, ACTIVE} state_e;

  state_e                   state_q, state_d;
  logic [T_ID_WIDTH-1:0]    sel_q, sel_d;
  logic [T_ID_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
  logic [DEFICIT_WIDTH-1:0] deficit_q [STREAM_COUNT];
  logic [DEFICIT_WIDTH-1:0] deficit_d [STREAM_COUNT];

  logic [SUM_WIDTH-1:0]     refill_sum [STREAM_COUNT];
  logic [DEFICIT_WIDTH-1:0] refill_val [STREAM_COUNT];
  logic                     cand_found;
  logic [T_ID_WIDTH-1:0]    cand_idx;
  logic [T_ID_WIDTH-1:0]    scan_idx;
  logic [DEFICIT_WIDTH-1:0] dec_val;
  logic [T_ID_WIDTH-1:0]    next_sel;

  // Refill value per stream: a zero weight still grants one beat; saturate at max.
  always_comb begin
    for (int i = 0; i < int'(STREAM_COUNT); i++) begin
      refill_sum[i] = SUM_WIDTH'(deficit_q[i]) +
                      ((s_weight_in[i] == '0) ? SUM_WIDTH'(1) : SUM_WIDTH'(s_weight_in[i]));
      if (!s_valid_in[i])
        refill_val[i] = '0;
      else if (refill_sum[i] > D_MAX)
        refill_val[i] = DEFICIT_WIDTH'(D_MAX);
      else
        refill_val[i] = DEFICIT_WIDTH'(refill_sum[i]);
    end
  end

  // First valid stream with credit, scanning from rr_ptr.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    scan_idx   = '0;
    for (int k = 0; k < int'(STREAM_COUNT); k++) begin
      scan_idx = T_ID_WIDTH'((32'(rr_ptr_q) + 32'(k)) % STREAM_COUNT);
      if (!cand_found && s_valid_in[scan_idx] && (deficit_q[scan_idx] != '0)) begin
        cand_found = 1'b1;
        cand_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    rr_ptr_d    = rr_ptr_q;
    deficit_d   = deficit_q;
    m_valid_out = 1'b0;
    m_data_out  = '0;
    m_last_out  = 1'b0;
    m_id_out    = '0;
    s_ready_out = '0;
    dec_val     = (deficit_q[sel_q] == '0) ? '0 : deficit_q[sel_q] - DEFICIT_WIDTH'(1);
    next_sel    = (sel_q == T_ID_WIDTH'(STREAM_COUNT - 1)) ? '0 : sel_q + T_ID_WIDTH'(1);
    case (state_q)
      IDLE: begin
        if (cand_found) begin
          sel_d   = cand_idx;
          state_d = ACTIVE;
        end else if (|s_valid_in) begin
          state_d = REFILL;
        end
      end
      REFILL: begin
        deficit_d = refill_val;
        state_d   = IDLE;
      end
      ACTIVE: begin
        m_valid_out        = s_valid_in[sel_q];
        m_data_out         = s_data_in[sel_q];
        m_last_out         = s_last_in[sel_q];
        m_id_out           = sel_q;
        s_ready_out[sel_q] = m_ready_in;
        if (s_valid_in[sel_q] && m_ready_in) begin
          deficit_d[sel_q] = dec_val;
          // Packet end: stay on this stream while it still has credit.
          if (s_last_in[sel_q]) begin
            state_d  = IDLE;
            rr_ptr_d = (dec_val != '0) ? sel_q : next_sel;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      rr_ptr_q <= '0;
      for (int i = 0; i < int'(STREAM_COUNT); i++) deficit_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      for (int i = 0; i < int'(STREAM_COUNT); i++) deficit_q[i] <= deficit_d[i];
    end
  end

endmodule
